spi_reg_responder: RTL
======================

# spi_reg_responder

SPI mode-0 register-access responder: the peripheral end of the link driven by the team's SPI master (MSB first, 8-bit frames, CS active-low). Oversamples SCLK/CS/MOSI on the system Clock, decodes a command byte plus one or more data bytes, and turns them into single-cycle register read/write strobes toward local register logic. Sits between the external SPI pins and a device-side register bank.

## Interface
- `ADDR_W`, 7: register address width; the command byte carries `{rw, addr[6:0]}`.
- `CMD_FILL`, 8'h00: byte driven on MISO while the command byte is received.
- `Clock`  in  1  system clock; SCLK ≤ Clock/8.
- `Reset`  in  1  asynchronous, active-low reset.
- `SCLK`  in  1  SPI clock from the master, asynchronous to Clock.
- `CS`  in  1  chip select, active-low, asynchronous.
- `MOSI`  in  1  master-to-responder data.
- `MISO`  inout  1  driven only while the frame is active, `1'bz` otherwise.
- `reg_addr`  out  ADDR_W  current register address.
- `reg_wdata`  out  8  write data, valid with `reg_we`.
- `reg_we`  out  1  one-cycle write strobe.
- `reg_re`  out  1  one-cycle read strobe.
- `reg_rdata`  in  8  read data; must be valid the cycle after `reg_re`.
- `busy`  out  1  high while a frame is active.
- `frame_err`  out  1  one-cycle pulse when CS rises mid-byte.

## Operation
- Inputs pass through 2-FF synchronizers. Edges are detected on the synchronized values: `sclk_rise`, `sclk_fall`, `cs_fall`, `cs_rise`.
- States:
  - `S_LOCK`: entered after reset. Waits for synchronized CS high, then goes to `S_IDLE`. A frame already in progress at reset is ignored.
  - `S_IDLE`: on `cs_fall`, go to `S_CMD`, clear the bit counter, and load the shift-out register with `CMD_FILL`.
  - `S_CMD`: on each `sclk_rise`, sample MOSI into the shift-in register. On each `sclk_fall`, shift the shift-out register left. After the 8th rise:
    - latch `rw` and `addr`.
    - if `rw=1`, pulse `reg_re` the next cycle.
    - on the following `sclk_fall`, load the shift-out register with `reg_rdata` instead of shifting, then go to `S_DATA`.
  - `S_DATA`: same bit timing as `S_CMD`. At the 8th rise of each byte:
    - write (`rw=0`): drive `reg_wdata` = received byte and pulse `reg_we`.
    - read (`rw=1`): increment the address, pulse `reg_re`, and load the next `reg_rdata` at the next fall.
    - write: increment the address after the `reg_we` cycle.
- Address increment wraps 127 → 0 (modulo 2^ADDR_W).
- On `cs_rise` from `S_CMD` or `S_DATA`:
  - bit counter ≠ 0: discard the partial byte, no strobe, pulse `frame_err`.
  - then go to `S_IDLE`.
- A frame containing only a complete command byte is legal and has no side effects beyond a `reg_re` for reads.
- MISO = shift-out MSB when `busy` and synchronized CS low; `1'bz` otherwise.
- `reg_we` and `reg_re` are never high in the same cycle.

## Timing
- Reset values:
  - outputs: `reg_addr`=0, `reg_wdata`=0, `reg_we`=0, `reg_re`=0, `busy`=0, `frame_err`=0, MISO=z.
  - internal: state `S_LOCK`, bit counter 0.
- Edge-detect latency: 3 Clock cycles from the pin edge to the internal action (2 sync + 1 edge register).
- Write: `reg_we` asserts 4 cycles after the 8th data-byte SCLK rise at the pin, for exactly 1 cycle.
- Read: `reg_re` follows the 8th rise by 4 cycles. `reg_rdata` is sampled 1 cycle later. The MSB appears on MISO 3 cycles after the SCLK fall at the pin. This requires an SCLK half-period ≥ 4 Clock cycles; the master default of div=5 satisfies it.
- `busy` rises 3 cycles after CS falls at the pin and falls 3 cycles after CS rises.
- `frame_err` is asserted in the same cycle `busy` falls.
- Reset asserted mid-frame: everything returns to reset values immediately, MISO releases, and the block re-enters `S_LOCK`.

## Structure
- Shared package `spi_pkg` holds:
  - state encodings `S_LOCK`, `S_IDLE`, `S_CMD`, `S_DATA`;
  - `SPI_BYTE_W`=8;
  - `RW_BIT`=7;
  - the default `CMD_FILL`.
- Sub-module `spi_pin_sync`: 2-FF synchronizer with rise/fall detect, instantiated for SCLK and CS. MOSI uses the synchronizer only.

## Test plan
- Write burst: CS low, bytes 0x05, 0x3C, 0x7E, CS high → `reg_we` twice, with (addr 5, 0x3C) then (addr 6, 0x7E); `frame_err`=0.
- Read burst: command 0x82, register model returns 0xA7 @2 and 0x19 @3 → master receives 0x00, 0xA7, 0x19; `reg_re` three times at addr 2, 3, 4.
- Wrap: write command 0x7F followed by 2 data bytes → writes land at addr 127 then 0.
- Abort: CS rises after 4 bits of a data byte → no `reg_we` for that byte, one `frame_err` pulse, next frame decodes normally.
- Reset mid-read frame: MISO=z within 1 cycle, outputs at reset values. Bytes clocked while CS stays low are ignored. After a CS high → low, a fresh frame works.
- Idle bus: CS high with SCLK toggling → no strobes, MISO=z, `busy`=0.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register responder: FSM encodings, byte
// geometry and the command-byte layout.
package spi_pkg;

  localparam int SPI_BYTE_W = 8;
  localparam int RW_BIT     = 7;

  localparam logic [SPI_BYTE_W-1:0] CMD_FILL_DEFAULT = 8'h00;

  localparam logic [1:0] S_LOCK = 2'd0;
  localparam logic [1:0] S_IDLE = 2'd1;
  localparam logic [1:0] S_CMD  = 2'd2;
  localparam logic [1:0] S_DATA = 2'd3;

  typedef struct packed {
    logic              rw;
    logic [RW_BIT-1:0] addr;
  } cmd_t;

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchronizer for an asynchronous pin plus one edge-history flop
// for rise/fall detection on the synchronized value.
module spi_pin_sync (
  input  logic Clock,
  input  logic Reset,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [2:0] ff;

  // Reset low so a CS held low through reset never looks like a fresh fall.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) ff <= '0;
    else        ff <= {ff[1:0], din};
  end

  assign sync = ff[1];
  assign rise = ff[1] & ~ff[2];
  assign fall = ~ff[1] & ff[2];

endmodule

// File: rtl/spi_reg_responder.sv
// SPI mode-0 responder: command byte {rw, addr} followed by a data burst,
// turned into single-cycle register read/write strobes.
module spi_reg_responder
  import spi_pkg::*;
#(
  parameter int                    ADDR_W   = 7,
  parameter logic [SPI_BYTE_W-1:0] CMD_FILL = CMD_FILL_DEFAULT
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  SCLK,
  input  logic                  CS,
  input  logic                  MOSI,
  inout  wire logic             MISO,
  output logic [ADDR_W-1:0]     reg_addr,
  output logic [SPI_BYTE_W-1:0] reg_wdata,
  output logic                  reg_we,
  output logic                  reg_re,
  input  logic [SPI_BYTE_W-1:0] reg_rdata,
  output logic                  busy,
  output logic                  frame_err
);

  localparam int CNT_W = $clog2(SPI_BYTE_W);

  logic sclk_rise, sclk_fall, sclk_sync_unused;
  logic cs_s, cs_rise, cs_fall;
  logic [1:0] mosi_ff;

  logic [1:0]            state;
  logic [CNT_W-1:0]      bit_cnt;
  logic [SPI_BYTE_W-1:0] shift_in, shift_out, rdata_q;
  logic                  rw, byte_done, inc_pend, re_q;
  cmd_t                  cmd;

  spi_pin_sync u_sclk (
    .Clock(Clock), .Reset(Reset), .din(SCLK),
    .sync(sclk_sync_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_pin_sync u_cs (
    .Clock(Clock), .Reset(Reset), .din(CS),
    .sync(cs_s), .rise(cs_rise), .fall(cs_fall)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) mosi_ff <= '0;
    else        mosi_ff <= {mosi_ff[0], MOSI};
  end

  assign cmd  = cmd_t'(shift_in);
  assign busy = (state == S_CMD) || (state == S_DATA);
  assign MISO = (busy && !cs_s) ? shift_out[SPI_BYTE_W-1] : 1'bz;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state     <= S_LOCK;
      bit_cnt   <= '0;
      shift_in  <= '0;
      shift_out <= '0;
      rdata_q   <= '0;
      rw        <= 1'b0;
      byte_done <= 1'b0;
      inc_pend  <= 1'b0;
      re_q      <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      frame_err <= 1'b0;
      byte_done <= 1'b0;
      inc_pend  <= 1'b0;
      re_q      <= reg_re;

      // Read data is captured one cycle after the strobe, well before the
      // SCLK fall that moves it into the shifter.
      if (re_q) rdata_q <= reg_rdata;

      // Writes advance the address only after the strobe cycle has used it.
      if (inc_pend) reg_addr <= reg_addr + ADDR_W'(1);

      // Strobes trail the completing rise by one cycle; a CS rise landing
      // in that gap must not swallow a complete byte.
      if (byte_done && busy) begin
        if (state == S_CMD) begin
          reg_addr <= ADDR_W'(cmd.addr);
          rw       <= cmd.rw;
          reg_re   <= cmd.rw;
        end else if (rw) begin
          reg_addr <= reg_addr + ADDR_W'(1);
          reg_re   <= 1'b1;
        end else begin
          reg_wdata <= shift_in;
          reg_we    <= 1'b1;
          inc_pend  <= 1'b1;
        end
      end

      case (state)
        S_LOCK: if (cs_s) state <= S_IDLE;
        S_IDLE: begin
          if (cs_fall) begin
            state     <= S_CMD;
            bit_cnt   <= '0;
            shift_out <= CMD_FILL;
          end
        end
        default: begin
          if (cs_rise) begin
            state     <= S_IDLE;
            frame_err <= (bit_cnt != '0);
          end else begin
            if (sclk_rise) begin
              shift_in  <= {shift_in[SPI_BYTE_W-2:0], mosi_ff[1]};
              bit_cnt   <= bit_cnt + CNT_W'(1);
              byte_done <= (bit_cnt == CNT_W'(SPI_BYTE_W-1));
            end
            // A fall with the counter at zero closes a byte boundary.
            if (sclk_fall) begin
              if (bit_cnt == '0) begin
                shift_out <= rdata_q;
                state     <= S_DATA;
              end else begin
                shift_out <= {shift_out[SPI_BYTE_W-2:0], 1'b0};
              end
            end
          end
        end
      endcase
    end
  end

endmodule
